// File: rtl/mult_div_unit_if.sv
// Operand/result bundle between the MIPS register file, control and the
// multiply/divide unit.
interface mult_div_unit_if #(parameter int WIDTH = 32);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] operand_a;
  logic [WIDTH-1:0] operand_b;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, operand_a, operand_b,
    input  busy, done, div_by_zero, hi, lo
  );

  modport slave (
    input  start, op, operand_a, operand_b,
    output busy, done, div_by_zero, hi, lo
  );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers.
// Shift-add multiply and restoring divide, one bit per cycle over WIDTH cycles.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input logic            clock,
  input logic            reset_n,
  mult_div_unit_if.slave bus
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   orig_a_q, orig_a_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               is_div_q, is_div_d;
  logic               neg_q, neg_d;
  logic               rem_neg_q, rem_neg_d;
  logic               dbz_q, dbz_d;
  logic               done_q, done_d;

  logic               sgn_s;
  logic [WIDTH:0]     mul_sum_s;
  logic [WIDTH:0]     rem_shift_s;
  logic               rem_ge_s;
  logic [WIDTH:0]     rem_diff_s;
  logic [2*WIDTH-1:0] mul_step_s;
  logic [2*WIDTH-1:0] div_step_s;
  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0]   quot_s;
  logic [WIDTH-1:0]   rem_s;

  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic sgn);
    return (sgn && v[WIDTH-1]) ? -v : v;
  endfunction

  // One iteration of each algorithm; acc holds {partial, multiplier} or {remainder, quotient}
  assign sgn_s       = ~bus.op[0];
  assign mul_sum_s   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
  assign mul_step_s  = {mul_sum_s, acc_q[WIDTH-1:1]};
  assign rem_shift_s = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign rem_ge_s    = rem_shift_s >= {1'b0, mcand_q};
  assign rem_diff_s  = rem_shift_s - {1'b0, mcand_q};
  assign div_step_s  = rem_ge_s ? {rem_diff_s[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1}
                                : {rem_shift_s[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
  assign prod_s      = neg_q ? -mul_step_s : mul_step_s;
  assign quot_s      = neg_q ? -div_step_s[WIDTH-1:0] : div_step_s[WIDTH-1:0];
  assign rem_s       = rem_neg_q ? -div_step_s[2*WIDTH-1:WIDTH] : div_step_s[2*WIDTH-1:WIDTH];

  // Next-state: accept in IDLE, iterate in RUN, commit HI/LO on the last iteration
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    orig_a_d  = orig_a_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    is_div_d  = is_div_q;
    neg_d     = neg_q;
    rem_neg_d = rem_neg_q;
    dbz_d     = dbz_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          case (bus.op)
            3'd0, 3'd1, 3'd2, 3'd3: begin
              state_d   = RUN;
              cnt_d     = '0;
              is_div_d  = bus.op[1];
              neg_d     = sgn_s & (bus.operand_a[WIDTH-1] ^ bus.operand_b[WIDTH-1]);
              rem_neg_d = sgn_s & bus.operand_a[WIDTH-1];
              orig_a_d  = bus.operand_a;
              // Multiply iterates over operand_b; divide shifts out operand_a
              if (bus.op[1]) begin
                acc_d   = {{WIDTH{1'b0}}, magnitude(bus.operand_a, sgn_s)};
                mcand_d = magnitude(bus.operand_b, sgn_s);
              end else begin
                acc_d   = {{WIDTH{1'b0}}, magnitude(bus.operand_b, sgn_s)};
                mcand_d = magnitude(bus.operand_a, sgn_s);
              end
            end
            3'd4: begin
              hi_d   = bus.operand_a;
              dbz_d  = 1'b0;
              done_d = 1'b1;
            end
            3'd5: begin
              lo_d   = bus.operand_a;
              dbz_d  = 1'b0;
              done_d = 1'b1;
            end
            default: begin
              state_d = IDLE;
            end
          endcase
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        acc_d = is_div_q ? div_step_s : mul_step_s;
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
          if (!is_div_q) begin
            hi_d  = prod_s[2*WIDTH-1:WIDTH];
            lo_d  = prod_s[WIDTH-1:0];
            dbz_d = 1'b0;
          end else if (mcand_q == '0) begin
            hi_d  = orig_a_q;
            lo_d  = '1;
            dbz_d = 1'b1;
          end else begin
            hi_d  = rem_s;
            lo_d  = quot_s;
            dbz_d = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      mcand_q   <= '0;
      orig_a_q  <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      dbz_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      orig_a_q  <= orig_a_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      is_div_q  <= is_div_d;
      neg_q     <= neg_d;
      rem_neg_q <= rem_neg_d;
      dbz_q     <= dbz_d;
      done_q    <= done_d;
    end
  end

  assign bus.busy        = (state_q == RUN);
  assign bus.done        = done_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.hi          = hi_q;
  assign bus.lo          = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: directed corner cases plus random ops
// checked against a plain-arithmetic reference model.
module tb_mult_div_unit;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
  } exp_t;

  logic clock;
  logic reset_n;
  mult_div_unit_if #(.WIDTH(32)) bus ();

  mult_div_unit #(.WIDTH(32)) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus)
  );

  exp_t        sb_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] mhi = 32'd0;
  logic [31:0] mlo = 32'd0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference: architectural results from ordinary integer arithmetic
  function automatic exp_t model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] cur_hi, input logic [31:0] cur_lo);
    exp_t        e;
    longint      sa, sb, q, r;
    logic [63:0] p, qv, rv;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    e.hi = cur_hi; e.lo = cur_lo; e.dbz = 1'b0;
    case (op)
      3'd0: begin p = 64'(sa * sb); e.hi = p[63:32]; e.lo = p[31:0]; end
      3'd1: begin p = {32'd0, a} * {32'd0, b}; e.hi = p[63:32]; e.lo = p[31:0]; end
      3'd2, 3'd3: begin
        if (b == 32'd0) begin
          e.hi = a; e.lo = 32'hFFFF_FFFF; e.dbz = 1'b1;
        end else if (op == 3'd2 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          e.hi = 32'd0; e.lo = 32'h8000_0000;
        end else if (op == 3'd2) begin
          q = sa / sb; r = sa % sb; qv = 64'(q); rv = 64'(r);
          e.lo = qv[31:0]; e.hi = rv[31:0];
        end else begin
          e.lo = a / b; e.hi = a % b;
        end
      end
      3'd4: e.hi = a;
      3'd5: e.lo = a;
      default: ;
    endcase
    return e;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation
  always @(negedge clock) begin
    if (bus.done === 1'b1) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("hi", bus.hi, e.hi);
        chk("lo", bus.lo, e.lo);
        chk("div_by_zero", {31'd0, bus.div_by_zero}, {31'd0, e.dbz});
      end
    end
  end

  // Issue one op (caller is #1 after a posedge), check busy/hold/latency; inj>0 fires an ignored DIVU
  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input int inj);
    exp_t        e;
    logic [31:0] hi0, lo0;
    int          lat;
    bit          hold_ok;
    hi0 = bus.hi; lo0 = bus.lo;
    e = model(op, a, b, mhi, mlo);
    mhi = e.hi; mlo = e.lo;
    sb_q.push_back(e);
    bus.start = 1'b1; bus.op = op; bus.operand_a = a; bus.operand_b = b;
    @(posedge clock); #1;
    bus.start = 1'b0; bus.operand_a = $urandom; bus.operand_b = $urandom;
    lat = 1; hold_ok = 1'b1;
    while (bus.done !== 1'b1 && lat < 40) begin
      if (bus.busy !== 1'b1 || bus.hi !== hi0 || bus.lo !== lo0) hold_ok = 1'b0;
      if (lat == inj) begin
        bus.start = 1'b1; bus.op = 3'd3; bus.operand_a = 32'd100; bus.operand_b = 32'd7;
      end else begin
        bus.start = 1'b0;
      end
      @(posedge clock); #1;
      lat++;
    end
    bus.start = 1'b0;
    chk("latency", 32'(lat), (op >= 3'd4) ? 32'd1 : 32'd33);
    chk("busy_hold", {31'd0, hold_ok}, 32'd1);
    chk("busy_at_done", {31'd0, bus.busy}, 32'd0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'd1;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int ndone;
    reset_n = 1'b0; bus.start = 1'b0; bus.op = 3'd0; bus.operand_a = 32'd0; bus.operand_b = 32'd0;
    repeat (3) @(posedge clock);
    #1 reset_n = 1'b1;
    chk("rst_hi", bus.hi, 32'd0);
    chk("rst_lo", bus.lo, 32'd0);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_done", {31'd0, bus.done}, 32'd0);
    chk("rst_dbz", {31'd0, bus.div_by_zero}, 32'd0);

    do_op(3'd1, 32'd7, 32'd6, 0);
    do_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    do_op(3'd0, 32'hFFFF_FFFF, 32'd2, 0);
    do_op(3'd0, 32'h8000_0000, 32'h8000_0000, 0);
    do_op(3'd2, 32'hFFFF_FFF9, 32'd2, 0);
    do_op(3'd3, 32'd17, 32'd5, 0);
    do_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    do_op(3'd3, 32'd17, 32'd0, 0);
    do_op(3'd5, 32'd5, 32'd0, 0);
    do_op(3'd1, 32'h1234_5678, 32'h9ABC_DEF0, 10);
    do_op(3'd4, 32'hCAFE_F00D, 32'd0, 0);

    // Reserved op: no done, no busy
    bus.start = 1'b1; bus.op = 3'd6; bus.operand_a = 32'hDEAD_BEEF;
    @(posedge clock); #1 bus.start = 1'b0;
    ndone = 0;
    repeat (4) begin
      if (bus.done === 1'b1 || bus.busy === 1'b1) ndone++;
      @(posedge clock); #1;
    end
    chk("reserved_op_quiet", 32'(ndone), 32'd0);
    chk("reserved_hi_kept", bus.hi, mhi);

    for (int i = 0; i < 30; i++) begin
      do_op(3'($urandom_range(0, 5)), pick(), pick(), 0);
    end

    // Reset mid-RUN aborts the op
    bus.start = 1'b1; bus.op = 3'd0; bus.operand_a = 32'd123; bus.operand_b = 32'hFFFF_FF00;
    @(posedge clock); #1 bus.start = 1'b0;
    repeat (14) begin @(posedge clock); #1; end
    reset_n = 1'b0;
    @(posedge clock); #1 reset_n = 1'b1;
    mhi = 32'd0; mlo = 32'd0;
    chk("abort_busy", {31'd0, bus.busy}, 32'd0);
    chk("abort_hi", bus.hi, 32'd0);
    chk("abort_lo", bus.lo, 32'd0);
    ndone = 0;
    repeat (40) begin
      if (bus.done === 1'b1) ndone++;
      @(posedge clock); #1;
    end
    chk("abort_no_done", 32'(ndone), 32'd0);

    do_op(3'd3, 32'd100, 32'd7, 0);
    @(posedge clock); #1;
    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Multi-cycle integer multiply/divide unit with architectural HI/LO registers for the MIPS datapath. Sits directly downstream of the register file: operands come from the two register read ports, and HI/LO are read back through the `hi`/`lo` outputs for MFHI/MFLO. It executes MULT, MULTU, DIV and DIVU iteratively over 32 cycles, plus single-cycle MTHI/MTLO. It raises `busy` so control can stall dependent instructions.

## Interface
- `WIDTH`, 32: operand and HI/LO width; iteration count equals `WIDTH`.
- `clock` input 1: single clock; all state updates on the rising edge.
- `reset_n` input 1: synchronous, active-low reset.
- `start` input 1: request; accepted only in a cycle with `busy`=0.
- `op` input 3: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; 6/7 reserved.
- `operand_a` input WIDTH: rs value (register read port 1); dividend / multiplicand / MTHI-MTLO source.
- `operand_b` input WIDTH: rt value (register read port 2); divisor / multiplier.
- `busy` output 1: iterative operation in progress.
- `done` output 1: one-cycle pulse; HI/LO hold the new result in this cycle.
- `div_by_zero` output 1: valid with `done`; set when the completed DIV/DIVU had `operand_b`=0.
- `hi` output WIDTH: HI register.
- `lo` output WIDTH: LO register.

## Operation
- States: IDLE, RUN. Reset → IDLE.
- Reset values: `hi`=0, `lo`=0, `busy`=0, `done`=0, `div_by_zero`=0, iteration counter=0.
- Accept: `start`=1, `busy`=0, `op` valid. `op`=6/7 with `start` is ignored: no state change, no `done`.
- MTHI/MTLO: `hi` (resp. `lo`) ← `operand_a` at the accepting edge. `done`=1 the next cycle. Stays IDLE, `busy` never asserts, `div_by_zero`=0.
- MULT/DIV ops: the accepting edge latches operand magnitudes, the result-sign flags and the op into internal registers. State → RUN, `busy`=1, counter=0.
- Signed ops use magnitudes (two's-complement absolute value; 0x80000000 magnitude is 2^31 unsigned). Unsigned ops use raw values.
- Multiply: shift-add, one multiplier bit per cycle, 2·WIDTH-bit accumulator. Final product is negated if the operand signs differ (signed only). HI = upper WIDTH bits, LO = lower.
- Divide: restoring, one quotient bit per cycle. LO = quotient, HI = remainder.
  - Signed quotient is negated if the signs differ.
  - Signed remainder takes the sign of the dividend.
  - 0x80000000 / -1 gives LO=0x80000000, HI=0.
- Divide by zero: no trap. HI = `operand_a` (original value), LO = all ones, `div_by_zero`=1. Latency is unchanged.
- `hi`/`lo` are written only on completion. They hold their old values throughout RUN, so MFHI/MFLO during `busy` return the previous result. Control must stall on `busy`.
- `start` during RUN is ignored. No queueing.
- `div_by_zero` updates on every completion (0 for non-divide ops) and holds until the next completion.

## Timing
- Cycle 0: `start`=1, `busy`=0. The edge ending cycle 0 latches operands; `busy`=1 from cycle 1.
- Iterations happen on the edges ending cycles 1..WIDTH.
- The edge ending cycle WIDTH writes `hi`/`lo`/`div_by_zero` and clears `busy`. `done`=1 in cycle WIDTH+1 only.
- Latency start→result visible: WIDTH+1 cycles (33). Back-to-back: a new `start` is accepted in cycle WIDTH+1, the same cycle as `done`.
- MTHI/MTLO: result and `done` in cycle 1.
- Inputs are sampled only at the accepting edge. `operand_a`/`operand_b` may change afterwards.
- `reset_n`=0 at any edge, including mid-RUN, aborts the operation. It forces all reset values on that edge, and no `done` is produced for the aborted op.

## Test plan
- MULTU 7×6 at cycle 0 → `busy` cycles 1–32, `done` cycle 33, `hi`=0, `lo`=42. MULTU 0xFFFFFFFF×0xFFFFFFFF → `hi`=0xFFFFFFFE, `lo`=0x00000001.
- MULT −1×2 → `hi`=0xFFFFFFFF, `lo`=0xFFFFFFFE. MULT 0x80000000×0x80000000 → `hi`=0x40000000, `lo`=0.
- DIV −7/2 → `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF. DIVU 17/5 → `lo`=3, `hi`=2. DIV 0x80000000/−1 → `lo`=0x80000000, `hi`=0.
- DIVU 17/0 → `done` cycle 33, `div_by_zero`=1, `hi`=17, `lo`=0xFFFFFFFF. A following MTLO 5 → `lo`=5, `done` next cycle, `div_by_zero`=0.
- MULTU started; `start` with DIVU at cycle 10 → ignored; result is the MULTU product at cycle 33. `hi`/`lo` hold their prior values during cycles 1–32. `op`=6 in IDLE → no `done`.
- MULT started; `reset_n`=0 at cycle 15 → `busy`=0, `hi`=`lo`=0, and no `done` in the following 40 cycles.
